// File: rtl/pipe_controller_if.sv
// Handshake and control-word bundle between fetch, pipe_controller and the execute stage.
// The controller takes the slave side; the fetch/execute environment takes the master side.
`ifndef OP_CODE_LEN
`define OP_CODE_LEN 5
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

interface pipe_controller_if #(
  parameter int OP_LEN  = `OP_CODE_LEN,
  parameter int CMD_LEN = `EXE_CMD_LEN
);
  logic               in_valid;
  logic               in_ready;
  logic [OP_LEN-1:0]  opCode;
  logic               BEQ;
  logic               BLT;
  logic               out_valid;
  logic               BranchEn;
  logic [CMD_LEN-1:0] EXE_CMD;
  logic               ImSel;
  logic               Reg_W_En;
  logic               IncreaseTK;
  logic               BranchTK;
  logic               Stall;
  logic               Flush;
  logic               illegal_op;

  modport master (
    output in_valid, opCode, BEQ, BLT,
    input  in_ready, out_valid, BranchEn, EXE_CMD, ImSel, Reg_W_En,
           IncreaseTK, BranchTK, Stall, Flush, illegal_op
  );

  modport slave (
    input  in_valid, opCode, BEQ, BLT,
    output in_ready, out_valid, BranchEn, EXE_CMD, ImSel, Reg_W_En,
           IncreaseTK, BranchTK, Stall, Flush, illegal_op
  );
endinterface

// File: rtl/pipe_controller.sv
// Pipeline control unit: decodes one instruction per accept into a registered control word,
// sequences multi-cycle multiplies (MULWAIT) and front-end squashes after taken branches (FLUSH).
`ifndef OP_CODE_LEN
`define OP_CODE_LEN 5
`endif
`ifndef EXE_CMD_LEN
`define EXE_CMD_LEN 4
`endif

`ifndef PIPE_CONTROLLER_OPCODES
`define PIPE_CONTROLLER_OPCODES
`define ADD      5'd1
`define SUB      5'd2
`define AND      5'd3
`define OR       5'd4
`define XOR      5'd5
`define SLL      5'd6
`define SRL      5'd7
`define MUL      5'd8
`define ADDI     5'd9
`define ANDI     5'd10
`define ORI      5'd11
`define XORI     5'd12
`define SLLI     5'd13
`define SRLI     5'd14
`define BEQ      5'd15
`define BLT      5'd16
`define J        5'd17

`define EXE_NOP  4'd0
`define EXE_ADD  4'd1
`define EXE_SUB  4'd2
`define EXE_AND  4'd3
`define EXE_OR   4'd4
`define EXE_XOR  4'd5
`define EXE_SLL  4'd6
`define EXE_SRL  4'd7
`define EXE_MUL  4'd8
`endif

module pipe_controller #(
  parameter int OP_LEN       = `OP_CODE_LEN,
  parameter int CMD_LEN      = `EXE_CMD_LEN,
  parameter int MUL_LAT      = 3,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  pipe_controller_if.slave bus
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LOAD   = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] MUL_ONE    = CW'(1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  typedef enum logic [1:0] {RUN, MULWAIT, FLUSH} state_t;
  typedef enum logic [2:0] {K_ALU, K_MUL, K_BRANCH, K_JUMP, K_ILLEGAL} kind_t;

  state_t             r_state;
  logic [CW-1:0]      r_mul_cnt;
  logic [FW-1:0]      r_flush_cnt;
  logic               r_out_valid;
  logic               r_branch_en;
  logic [CMD_LEN-1:0] r_exe_cmd;
  logic               r_im_sel;
  logic               r_reg_w_en;
  logic               r_increase_tk;
  logic               r_branch_tk;
  logic               r_stall;
  logic               r_flush;
  logic               r_illegal_op;

  kind_t              w_kind;
  logic [CMD_LEN-1:0] w_cmd;
  logic               w_imm;
  logic               w_taken;
  logic               w_accept;

  assign bus.in_ready = (r_state == RUN) && !rst;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // Instruction classification; the branch flags are only meaningful alongside their opcode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_kind  = K_ILLEGAL;
    w_cmd   = `EXE_NOP;
    w_imm   = 1'b0;
    w_taken = 1'b0;
    case (bus.opCode)
      `ADD:  begin w_kind = K_ALU; w_cmd = `EXE_ADD; end
      `SUB:  begin w_kind = K_ALU; w_cmd = `EXE_SUB; end
      `AND:  begin w_kind = K_ALU; w_cmd = `EXE_AND; end
      `OR:   begin w_kind = K_ALU; w_cmd = `EXE_OR;  end
      `XOR:  begin w_kind = K_ALU; w_cmd = `EXE_XOR; end
      `SLL:  begin w_kind = K_ALU; w_cmd = `EXE_SLL; end
      `SRL:  begin w_kind = K_ALU; w_cmd = `EXE_SRL; end
      `ADDI: begin w_kind = K_ALU; w_cmd = `EXE_ADD; w_imm = 1'b1; end
      `ANDI: begin w_kind = K_ALU; w_cmd = `EXE_AND; w_imm = 1'b1; end
      `ORI:  begin w_kind = K_ALU; w_cmd = `EXE_OR;  w_imm = 1'b1; end
      `XORI: begin w_kind = K_ALU; w_cmd = `EXE_XOR; w_imm = 1'b1; end
      `SLLI: begin w_kind = K_ALU; w_cmd = `EXE_SLL; w_imm = 1'b1; end
      `SRLI: begin w_kind = K_ALU; w_cmd = `EXE_SRL; w_imm = 1'b1; end
      `MUL:  begin w_kind = K_MUL; w_cmd = `EXE_MUL; end
      `BEQ:  begin w_kind = K_BRANCH; w_taken = bus.BEQ; end
      `BLT:  begin w_kind = K_BRANCH; w_taken = bus.BLT; end
      `J:    w_kind = K_JUMP;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    if (rst) begin
      r_state       <= RUN;
      r_mul_cnt     <= '0;
      r_flush_cnt   <= '0;
      r_out_valid   <= 1'b0;
      r_branch_en   <= 1'b0;
      r_exe_cmd     <= `EXE_NOP;
      r_im_sel      <= 1'b0;
      r_reg_w_en    <= 1'b0;
      r_increase_tk <= 1'b0;
      r_branch_tk   <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      r_illegal_op  <= 1'b0;
    end else begin
      // Every cycle is a bubble unless a branch below says otherwise; illegal_op stays sticky.
      r_out_valid   <= 1'b0;
      r_branch_en   <= 1'b0;
      r_exe_cmd     <= `EXE_NOP;
      r_im_sel      <= 1'b0;
      r_reg_w_en    <= 1'b0;
      r_increase_tk <= 1'b0;
      r_branch_tk   <= 1'b0;
      r_stall       <= 1'b0;
      r_flush       <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_accept) begin
            case (w_kind)
              K_ALU: begin
                r_out_valid   <= 1'b1;
                r_exe_cmd     <= w_cmd;
                r_im_sel      <= w_imm;
                r_reg_w_en    <= 1'b1;
                r_increase_tk <= 1'b1;
              end
              K_MUL: begin
                r_exe_cmd <= w_cmd;
                if (MUL_LAT == 1) begin
                  r_out_valid   <= 1'b1;
                  r_reg_w_en    <= 1'b1;
                  r_increase_tk <= 1'b1;
                end else begin
                  r_state   <= MULWAIT;
                  r_mul_cnt <= MUL_LOAD;
                  r_stall   <= 1'b1;
                end
              end
              K_BRANCH: begin
                r_out_valid <= 1'b1;
                r_branch_en <= 1'b1;
                if (w_taken) begin
                  r_branch_tk <= 1'b1;
                  r_flush     <= 1'b1;
                  r_flush_cnt <= FLUSH_LOAD;
                  r_state     <= FLUSH;
                end else begin
                  r_increase_tk <= 1'b1;
                end
              end
              K_JUMP: begin
                r_out_valid <= 1'b1;
                r_branch_tk <= 1'b1;
                r_flush     <= 1'b1;
                r_flush_cnt <= FLUSH_LOAD;
                r_state     <= FLUSH;
              end
              default: begin
                r_out_valid   <= 1'b1;
                r_increase_tk <= 1'b1;
                r_illegal_op  <= 1'b1;
              end
            endcase
          end
        end
        MULWAIT: begin
          r_exe_cmd <= `EXE_MUL;
          if (r_mul_cnt == MUL_ONE) begin
            r_mul_cnt     <= '0;
            r_state       <= RUN;
            r_out_valid   <= 1'b1;
            r_reg_w_en    <= 1'b1;
            r_increase_tk <= 1'b1;
          end else begin
            r_mul_cnt <= r_mul_cnt - MUL_ONE;
            r_stall   <= 1'b1;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= RUN;
          end else begin
            r_flush_cnt <= r_flush_cnt - FLUSH_ONE;
            r_flush     <= 1'b1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.BranchEn   = r_branch_en;
  assign bus.EXE_CMD    = r_exe_cmd;
  assign bus.ImSel      = r_im_sel;
  assign bus.Reg_W_En   = r_reg_w_en;
  assign bus.IncreaseTK = r_increase_tk;
  assign bus.BranchTK   = r_branch_tk;
  assign bus.Stall      = r_stall;
  assign bus.Flush      = r_flush;
  assign bus.illegal_op = r_illegal_op;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench for pipe_controller: instance A (MUL_LAT=3, FLUSH_CYCLES=2) covers the main
// decode, multiply and flush sequences; instance B (MUL_LAT=1, FLUSH_CYCLES=1) covers the minimal timings.
module tb_pipe_controller;

  localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3,  OP_OR = 5'd4;
  localparam logic [4:0] OP_XOR = 5'd5,  OP_SLL = 5'd6,  OP_SRL = 5'd7,  OP_MUL = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9, OP_ANDI = 5'd10, OP_ORI = 5'd11, OP_XORI = 5'd12;
  localparam logic [4:0] OP_SLLI = 5'd13, OP_SRLI = 5'd14, OP_BEQ = 5'd15, OP_BLT = 5'd16;
  localparam logic [4:0] OP_J = 5'd17, OP_BAD = 5'd0;
  localparam logic [3:0] X_NOP = 4'd0, X_ADD = 4'd1, X_SUB = 4'd2, X_AND = 4'd3, X_OR = 4'd4;
  localparam logic [3:0] X_XOR = 4'd5, X_SLL = 4'd6, X_SRL = 4'd7, X_MUL = 4'd8;

  typedef struct {
    logic [4:0] op;
    logic [3:0] cmd;
    logic       imm;
  } alu_vec_t;

  alu_vec_t alu_vecs [13] = '{
    '{OP_ADD, X_ADD, 1'b0}, '{OP_SUB, X_SUB, 1'b0}, '{OP_AND, X_AND, 1'b0},
    '{OP_OR, X_OR, 1'b0},   '{OP_XOR, X_XOR, 1'b0}, '{OP_SLL, X_SLL, 1'b0},
    '{OP_SRL, X_SRL, 1'b0}, '{OP_ADDI, X_ADD, 1'b1}, '{OP_ANDI, X_AND, 1'b1},
    '{OP_ORI, X_OR, 1'b1},  '{OP_XORI, X_XOR, 1'b1}, '{OP_SLLI, X_SLL, 1'b1},
    '{OP_SRLI, X_SRL, 1'b1}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipe_controller_if #(.OP_LEN(5), .CMD_LEN(4)) bus_a ();
  pipe_controller_if #(.OP_LEN(5), .CMD_LEN(4)) bus_b ();

  pipe_controller #(.OP_LEN(5), .CMD_LEN(4), .MUL_LAT(3), .FLUSH_CYCLES(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  pipe_controller #(.OP_LEN(5), .CMD_LEN(4), .MUL_LAT(1), .FLUSH_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Control word packed as {out_valid, BranchEn, EXE_CMD, ImSel, Reg_W_En, IncreaseTK, BranchTK, Stall, Flush}.
  function automatic logic [11:0] ctl(input logic v, input logic be, input logic [3:0] cmd,
                                      input logic im, input logic we, input logic inc,
                                      input logic btk, input logic st, input logic fl);
    return {v, be, cmd, im, we, inc, btk, st, fl};
  endfunction

  function automatic logic [11:0] obs_a();
    return ctl(bus_a.out_valid, bus_a.BranchEn, bus_a.EXE_CMD, bus_a.ImSel, bus_a.Reg_W_En,
               bus_a.IncreaseTK, bus_a.BranchTK, bus_a.Stall, bus_a.Flush);
  endfunction

  function automatic logic [11:0] obs_b();
    return ctl(bus_b.out_valid, bus_b.BranchEn, bus_b.EXE_CMD, bus_b.ImSel, bus_b.Reg_W_En,
               bus_b.IncreaseTK, bus_b.BranchTK, bus_b.Stall, bus_b.Flush);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [4:0] op, input logic beq, input logic blt);
    bus_a.in_valid = v;
    bus_a.opCode   = op;
    bus_a.BEQ      = beq;
    bus_a.BLT      = blt;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] op);
    bus_b.in_valid = v;
    bus_b.opCode   = op;
    bus_b.BEQ      = 1'b0;
    bus_b.BLT      = 1'b0;
  endtask

  initial begin
    drive_a(1'b0, OP_ADD, 1'b0, 1'b0);
    drive_b(1'b0, OP_ADD);

    // Reset state and in_ready timing around reset release
    tick();
    tick();
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("rst_ctl", 32'(obs_a()), 32'd0);
    check("rst_illegal", 32'(bus_a.illegal_op), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus_a.in_ready), 32'd1);

    // Idle RUN cycle: everything 0, including IncreaseTK
    tick();
    check("idle_ctl", 32'(obs_a()), 32'd0);

    // Register-register and immediate ops, back to back
    foreach (alu_vecs[i]) begin
      drive_a(1'b1, alu_vecs[i].op, 1'b0, 1'b0);
      tick();
      check($sformatf("alu_%0d_ctl", alu_vecs[i].op), 32'(obs_a()),
            32'(ctl(1, 0, alu_vecs[i].cmd, alu_vecs[i].imm, 1, 1, 0, 0, 0)));
      check($sformatf("alu_%0d_ready", alu_vecs[i].op), 32'(bus_a.in_ready), 32'd1);
    end

    // Not-taken branches: BLT with BLT=0, BEQ with BEQ=0 but BLT=1 (must use its own flag)
    drive_a(1'b1, OP_BLT, 1'b1, 1'b0);
    tick();
    check("blt_nt_ctl", 32'(obs_a()), 32'(ctl(1, 1, X_NOP, 0, 0, 1, 0, 0, 0)));
    check("blt_nt_ready", 32'(bus_a.in_ready), 32'd1);
    drive_a(1'b1, OP_SUB, 1'b0, 1'b0);
    tick();
    check("after_blt_ctl", 32'(obs_a()), 32'(ctl(1, 0, X_SUB, 0, 1, 1, 0, 0, 0)));
    drive_a(1'b1, OP_BEQ, 1'b0, 1'b1);
    tick();
    check("beq_nt_ctl", 32'(obs_a()), 32'(ctl(1, 1, X_NOP, 0, 0, 1, 0, 0, 0)));

    // Taken BEQ with FLUSH_CYCLES=2; the ADD held during the flush must be ignored
    drive_a(1'b1, OP_BEQ, 1'b1, 1'b0);
    tick();
    check("beq_tk_ctl", 32'(obs_a()), 32'(ctl(1, 1, X_NOP, 0, 0, 0, 1, 0, 1)));
    check("beq_tk_ready", 32'(bus_a.in_ready), 32'd0);
    drive_a(1'b1, OP_ADD, 1'b0, 1'b0);
    tick();
    check("flush_bubble_ctl", 32'(obs_a()), 32'(ctl(0, 0, X_NOP, 0, 0, 0, 0, 0, 1)));
    check("flush_bubble_ready", 32'(bus_a.in_ready), 32'd0);
    tick();
    check("flush_end_ctl", 32'(obs_a()), 32'd0);
    check("flush_end_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("post_flush_add", 32'(obs_a()), 32'(ctl(1, 0, X_ADD, 0, 1, 1, 0, 0, 0)));

    // Taken BLT and jump
    drive_a(1'b1, OP_BLT, 1'b0, 1'b1);
    tick();
    check("blt_tk_ctl", 32'(obs_a()), 32'(ctl(1, 1, X_NOP, 0, 0, 0, 1, 0, 1)));
    drive_a(1'b0, OP_ADD, 1'b0, 1'b0);
    tick();
    tick();
    drive_a(1'b1, OP_J, 1'b1, 1'b1);
    tick();
    check("j_ctl", 32'(obs_a()), 32'(ctl(1, 0, X_NOP, 0, 0, 0, 1, 0, 1)));
    drive_a(1'b0, OP_ADD, 1'b0, 1'b0);
    tick();
    check("j_bubble", 32'(obs_a()), 32'(ctl(0, 0, X_NOP, 0, 0, 0, 0, 0, 1)));
    tick();
    check("j_end_ready", 32'(bus_a.in_ready), 32'd1);

    // MUL with MUL_LAT=3 while ADD is held on the input
    drive_a(1'b1, OP_MUL, 1'b0, 1'b0);
    tick();
    check("mul_w1_ctl", 32'(obs_a()), 32'(ctl(0, 0, X_MUL, 0, 0, 0, 0, 1, 0)));
    check("mul_w1_ready", 32'(bus_a.in_ready), 32'd0);
    drive_a(1'b1, OP_ADD, 1'b0, 1'b0);
    tick();
    check("mul_w2_ctl", 32'(obs_a()), 32'(ctl(0, 0, X_MUL, 0, 0, 0, 0, 1, 0)));
    tick();
    check("mul_done_ctl", 32'(obs_a()), 32'(ctl(1, 0, X_MUL, 0, 1, 1, 0, 0, 0)));
    check("mul_done_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    check("mul_then_add", 32'(obs_a()), 32'(ctl(1, 0, X_ADD, 0, 1, 1, 0, 0, 0)));

    // Unknown opcode: NOP word, sticky illegal_op until reset
    drive_a(1'b1, OP_BAD, 1'b0, 1'b0);
    tick();
    check("bad_ctl", 32'(obs_a()), 32'(ctl(1, 0, X_NOP, 0, 0, 1, 0, 0, 0)));
    check("bad_illegal", 32'(bus_a.illegal_op), 32'd1);
    drive_a(1'b1, OP_XOR, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, OP_ADD, 1'b0, 1'b0);
    tick();
    check("illegal_held", 32'(bus_a.illegal_op), 32'd1);
    rst = 1'b1;
    tick();
    check("illegal_cleared", 32'(bus_a.illegal_op), 32'd0);
    rst = 1'b0;

    // Reset one cycle into a MUL: no Stall, no Reg_W_En pulse afterwards
    drive_a(1'b1, OP_MUL, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive_a(1'b0, OP_ADD, 1'b0, 1'b0);
    tick();
    check("mul_rst_ctl", 32'(obs_a()), 32'd0);
    check("mul_rst_ready", 32'(bus_a.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mul_rst_release_ready", 32'(bus_a.in_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mul_rst_quiet_%0d", k), 32'(obs_a()), 32'd0);
    end

    // Reset during FLUSH aborts it
    drive_a(1'b1, OP_J, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive_a(1'b0, OP_ADD, 1'b0, 1'b0);
    tick();
    check("flush_rst_ctl", 32'(obs_a()), 32'd0);
    rst = 1'b0;
    #1;
    check("flush_rst_ready", 32'(bus_a.in_ready), 32'd1);

    // Instance B: MUL_LAT=1 behaves like a register op, FLUSH_CYCLES=1 is one cycle
    drive_b(1'b1, OP_MUL);
    tick();
    check("b_mul_ctl", 32'(obs_b()), 32'(ctl(1, 0, X_MUL, 0, 1, 1, 0, 0, 0)));
    check("b_mul_ready", 32'(bus_b.in_ready), 32'd1);
    drive_b(1'b1, OP_J);
    tick();
    check("b_j_ctl", 32'(obs_b()), 32'(ctl(1, 0, X_NOP, 0, 0, 0, 1, 0, 1)));
    check("b_j_ready", 32'(bus_b.in_ready), 32'd0);
    drive_b(1'b1, OP_ORI);
    tick();
    check("b_flush_end_ctl", 32'(obs_b()), 32'd0);
    check("b_flush_end_ready", 32'(bus_b.in_ready), 32'd1);
    tick();
    check("b_ori_ctl", 32'(obs_b()), 32'(ctl(1, 0, X_OR, 1, 1, 1, 0, 0, 0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
